// File: rtl/fir_mac_serial_if.sv
// Request/result bundle between the FIR tap source and the serial MAC stage.
// The master drives taps, coefficients and start; the slave returns the sum.
interface fir_mac_serial_if #(
    parameter int DELAY = 4,
    parameter int BITS  = 16,
    parameter int CBITS = 16,
    parameter int ACC_W = BITS + CBITS + $clog2(DELAY)
);
    logic [DELAY*BITS-1:0]   taps;
    logic [DELAY*CBITS-1:0]  coefs;
    logic                    start;
    logic signed [ACC_W-1:0] result;
    logic                    valid;
    logic                    busy;

    modport master (
        output taps, coefs, start,
        input  result, valid, busy
    );

    modport slave (
        input  taps, coefs, start,
        output result, valid, busy
    );
endinterface

// File: rtl/fir_mac_serial.sv
// Serial FIR multiply-accumulate: snapshots taps/coefs on start, then adds one
// signed tap*coef product per clock and strobes the full-precision sum.
//
// state  | meaning
// IDLE   | waiting for start; result holds the last completed sum
// MAC    | accumulating product idx; completes on idx = DELAY-1
module fir_mac_serial #(
    parameter int DELAY = 4,
    parameter int BITS  = 16,
    parameter int CBITS = 16,
    parameter int ACC_W = BITS + CBITS + $clog2(DELAY)
) (
    input logic           i_clk,
    input logic           i_rst,
    fir_mac_serial_if.slave bus
);
    localparam int IDX_W  = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int PROD_W = BITS + CBITS;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MAC  = 1'b1;

    logic [0:0]               state;
    logic [IDX_W-1:0]         idx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sum;
    logic signed [PROD_W-1:0] prod;
    logic                     last;
    logic signed [BITS-1:0]   snap_tap  [DELAY];
    logic signed [CBITS-1:0]  snap_coef [DELAY];

    assign prod     = snap_tap[idx] * snap_coef[idx];
    assign sum      = acc + ACC_W'(prod);
    assign last     = (idx == IDX_W'(DELAY - 1));
    assign bus.busy = (state == S_MAC);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            acc        <= '0;
            bus.result <= '0;
            bus.valid  <= 1'b0;
            for (int k = 0; k < DELAY; k++) begin
                snap_tap[k]  <= '0;
                snap_coef[k] <= '0;
            end
        end else begin
            bus.valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        for (int k = 0; k < DELAY; k++) begin
                            snap_tap[k]  <= bus.taps[k*BITS +: BITS];
                            snap_coef[k] <= bus.coefs[k*CBITS +: CBITS];
                        end
                        acc   <= '0;
                        idx   <= '0;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= sum;
                    idx <= idx + IDX_W'(1);
                    // start is deliberately not looked at here: requests during MAC are dropped
                    if (last) begin
                        bus.result <= sum;
                        bus.valid  <= 1'b1;
                        idx        <= '0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_mac_serial.sv
// Directed self-checking bench for fir_mac_serial at DELAY=4, 16x16 bits.
module tb_fir_mac_serial;
    localparam int DELAY = 4;
    localparam int BITS  = 16;
    localparam int CBITS = 16;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fir_mac_serial_if #(.DELAY(DELAY), .BITS(BITS), .CBITS(CBITS)) bus ();

    fir_mac_serial #(.DELAY(DELAY), .BITS(BITS), .CBITS(CBITS)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pack4(input logic [15:0] v0, input logic [15:0] v1,
                                          input logic [15:0] v2, input logic [15:0] v3);
        return {v3, v2, v1, v0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic busy_exp, input logic valid_exp);
        check({tag, "_busy"}, 34'(bus.busy), 34'(busy_exp));
        check({tag, "_valid"}, 34'(bus.valid), 34'(valid_exp));
    endtask

    // Full operation with a single start pulse; valid expected 4 edges after the start edge.
    task automatic run_op(input logic [63:0] t, input logic [63:0] c,
                          input logic [33:0] exp, input string tag);
        bus.taps  = t;
        bus.coefs = c;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check_ctl({tag, "_e0"}, 1'b1, 1'b0);
        for (int n = 1; n < DELAY; n++) begin
            step();
            check_ctl({tag, "_mac"}, 1'b1, 1'b0);
        end
        step();
        check_ctl({tag, "_done"}, 1'b0, 1'b1);
        check({tag, "_result"}, bus.result, exp);
        step();
        check_ctl({tag, "_after"}, 1'b0, 1'b0);
        check({tag, "_hold"}, bus.result, exp);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.taps  = '0;
        bus.coefs = '0;

        // reset with random activity on the inputs
        for (int n = 0; n < 3; n++) begin
            bus.taps  = {$urandom, $urandom};
            bus.coefs = {$urandom, $urandom};
            bus.start = 1'b1;
            step();
            check("rst_result", bus.result, 34'd0);
            check_ctl("rst", 1'b0, 1'b0);
        end
        rst       = 1'b1;
        bus.start = 1'b0;
        step();

        run_op(pack4(16'd1, 16'd2, 16'd3, 16'd4), pack4(16'd1, 16'd1, 16'd1, 16'd1),
               34'd10, "basic");
        run_op(pack4(16'd1, 16'd2, 16'd3, 16'd4), pack4(16'd1, -16'sd1, 16'd2, -16'sd2),
               -34'sd3, "mixed");
        run_op({4{16'h8000}}, {4{16'h8000}}, 34'h1_0000_0000, "neg_neg");
        run_op({4{16'h7fff}}, {4{16'h8000}}, -34'sd4294836224, "pos_neg");

        // taps change one cycle after capture must not leak into the sum
        bus.taps  = pack4(16'd1, 16'd2, 16'd3, 16'd4);
        bus.coefs = {4{16'd1}};
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.taps  = {4{16'd100}};
        for (int n = 1; n < DELAY; n++) step();
        step();
        check_ctl("snap", 1'b0, 1'b1);
        check("snap_result", bus.result, 34'd10);

        // start held high: one result every DELAY+1 cycles
        bus.taps  = pack4(16'd1, 16'd2, 16'd3, 16'd4);
        bus.coefs = {4{16'd1}};
        bus.start = 1'b1;
        for (int n = 0; n < 15; n++) begin
            step();
            check_ctl("cont", (n % 5) != 4, (n % 5) == 4);
            if ((n % 5) == 4) check("cont_result", bus.result, 34'd10);
        end
        bus.start = 1'b0;
        step();
        check_ctl("cont_end", 1'b0, 1'b0);

        // extra start during MAC is dropped
        bus.coefs = pack4(16'd2, 16'd2, 16'd2, 16'd2);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        check_ctl("extra_done", 1'b0, 1'b1);
        check("extra_result", bus.result, 34'd20);
        for (int n = 0; n < 6; n++) begin
            step();
            check_ctl("extra_idle", 1'b0, 1'b0);
        end

        // asynchronous reset two cycles into MAC
        bus.coefs = {4{16'd1}};
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        #2 rst = 1'b0;
        #1;
        check("midrst_result", bus.result, 34'd0);
        check_ctl("midrst", 1'b0, 1'b0);
        step();
        step();
        rst = 1'b1;
        for (int n = 0; n < 6; n++) begin
            step();
            check_ctl("post_rst", 1'b0, 1'b0);
            check("post_rst_result", bus.result, 34'd0);
        end
        run_op(pack4(16'd1, 16'd2, 16'd3, 16'd4), {4{16'd1}}, 34'd10, "recover");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
